rs232tx_buf: RTL and testbench
==============================

RS232TX_BUF -- requirements
Module: rs232tx_buf

Interface
REQ-001 SHALL have parameter FREQUENCY, default 50000000: clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115200: line rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8: character width, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter DEPTH, default 16: transmit FIFO entries, power of two, at least 2.
REQ-006 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port d, input, DATA_BITS bits: character to enqueue.
REQ-009 SHALL have port we, input, 1 bit: enqueue strobe, one character per cycle high.
REQ-010 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port serial_out, output, 1 bit: line, idle high.
REQ-012 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 SHALL have port busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-016 SHALL derive bit period PERIOD = (FREQUENCY + BPS/2) / BPS clock cycles, computed at elaboration; PERIOD below 2 is an elaboration error.
REQ-017 SHALL run a frame FSM with states IDLE, START, DATA, PARITY, STOP; each non-IDLE bit holds serial_out for exactly PERIOD cycles.
REQ-018 SHALL transmit start bit 0, then DATA_BITS data bits LSB first, then the optional parity bit, then STOP_BITS high bits.
REQ-019 SHALL latch parity_mode at the IDLE->START transition; changes mid-frame affect only the next frame.
REQ-020 SHALL enter PARITY only for modes 01/10; even makes the count of ones over data+parity even, odd makes it odd.
REQ-021 SHALL pop the FIFO head on the IDLE->START transition, taken whenever IDLE and level non-zero.
REQ-022 SHALL, with we high on edge N into an empty FIFO in IDLE, drive serial_out low from edge N+1; total latency is one cycle.
REQ-023 SHALL, at the end of the last stop bit with level non-zero, go directly to START with no idle gap.
REQ-024 SHALL drop a write while full is high, including when a pop occurs the same cycle, and pulse overflow for that cycle.
REQ-025 SHALL, on simultaneous non-full write and pop, leave level unchanged and keep order.
REQ-026 SHALL compute full and level from registered state only; busy is high whenever FSM is not IDLE or level non-zero.

Reset
REQ-027 SHALL, on reset_n low, asynchronously set serial_out 1, full 0, busy 0, level 0, overflow 0, FSM IDLE, and discard FIFO contents.
REQ-028 SHALL abort any frame on reset mid-transmission without completing it; the line is high until the next accepted write after release.

Configuration
REQ-029 SHALL compile parity support only when macro RS232TX_PARITY_EN is defined; when absent, the PARITY state and its logic are omitted, parity_mode is ignored, and frames are always no-parity.

Structure
REQ-030 SHALL place the FSM state enum and parity-mode encodings in shared package rs232_pkg for reuse by a future receiver.
REQ-031 SHALL implement the FIFO as sub-module rs232_fifo (DEPTH, WIDTH parameters; registered full/level; write-ignored-when-full).

Verification (FREQUENCY=8, BPS=1, so PERIOD=8)
REQ-032 SHALL verify a single write of d=8'hA5 with parity 00: line low 8 cycles from N+1, then bits 1,0,1,0,0,1,0,1 for 8 cycles each, then high 8 cycles; busy falls after 80 cycles.
REQ-033 SHALL verify d=8'h07, even mode with macro defined: parity bit 1; in odd mode it is 0; without the macro, no parity bit appears in either mode.
REQ-034 SHALL verify 3 back-to-back writes (8'h01, 8'h02, 8'h03): three frames with no idle gap; level peaks at 2, since the first is popped at once.
REQ-035 SHALL verify DEPTH=4 with 6 consecutive writes while a frame is active: level reaches 4, full asserts, and exactly one overflow pulse occurs for each dropped write.
REQ-036 SHALL verify reset_n pulsed low mid-DATA: serial_out goes 1 immediately, level 0, busy 0, and the next write produces a clean frame.
REQ-037 SHALL verify STOP_BITS=2, DATA_BITS=7: frame length 10*8 cycles, with the line high for the last 16.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: frame FSM states and parity-mode encodings,
// kept here so a future receiver can reuse them.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rs232_state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } rs232_parity_e;

    localparam int MAX_DATA_BITS = 9;

    function automatic logic parity_enabled(input rs232_parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Zero-extended data leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input rs232_parity_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Transmit FIFO: first-word-fall-through head, registered full/level,
// writes ignored while full, pops ignored while empty.
module rs232_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   we_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             push, pop;

    assign push = we_i & ~full_q;
    assign pop  = pop_i & (level_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d = (level_d == FULL_LVL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/rs232tx_buf.sv
// Buffered RS-232 transmitter: FIFO feeding a start/data/parity/stop frame FSM.
// Parity support is compiled in only when RS232TX_PARITY_EN is defined.
module rs232tx_buf
    import rs232_pkg::*;
#(
    parameter int FREQUENCY = 50000000,
    parameter int BPS       = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [DATA_BITS-1:0]   d,
    input  logic                   we,
    input  logic [1:0]             parity_mode,
    output logic                   serial_out,
    output logic                   full,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int PERIOD = (FREQUENCY + BPS / 2) / BPS;
    localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (PERIOD < 2) begin : g_bad_period
        $error("rs232tx_buf: bit period below 2 clock cycles");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("rs232tx_buf: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("rs232tx_buf: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rs232tx_buf: DEPTH must be a power of two, at least 2");
    end

    logic [DATA_BITS-1:0] head;
    logic                 pop;

    rs232_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wdata_i (d),
        .we_i    (we),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .level_o (level)
    );

    rs232_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_q, line_d;
    logic                 bit_end, load;
`ifdef RS232TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`else
    logic                 unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = line_q;
        load    = 1'b0;
`ifdef RS232TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (level != '0) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef RS232TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            line_d  = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
`else
                        state_d = ST_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
`ifdef RS232TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        // Back-to-back frames: next start bit follows the last stop bit directly.
                        if (level != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            line_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
            end
        endcase

        if (load) begin
            state_d = ST_START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = head;
            line_d  = 1'b0;
`ifdef RS232TX_PARITY_EN
            par_en_d  = parity_enabled(rs232_parity_e'(parity_mode));
            par_bit_d = parity_bit(MAX_DATA_BITS'(head), rs232_parity_e'(parity_mode));
`endif
        end
    end

    assign pop = load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            line_q  <= 1'b1;
`ifdef RS232TX_PARITY_EN
            par_en_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
`ifdef RS232TX_PARITY_EN
            par_en_q <= par_en_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_d;
`ifdef RS232TX_PARITY_EN
        par_bit_q <= par_bit_d;
`endif
    end

    assign serial_out = line_q;
    assign busy       = (state_q != ST_IDLE) || (level != '0);
    assign overflow   = we & full;

endmodule

// File: tb/tb_rs232tx_buf.sv
// Bench for rs232tx_buf at PERIOD=8: three instances (default, DEPTH=4,
// DATA_BITS=7/STOP_BITS=2) driven from a frame table plus corner sequences.
module tb_rs232tx_buf;

    logic       clk;
    logic       rst_a  [3];
    logic       we_a   [3];
    logic [1:0] pm_a   [3];
    logic       so_a   [3];
    logic       full_a [3];
    logic       busy_a [3];
    logic       ovf_a  [3];
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [4:0] lvl0;
    logic [2:0] lvl1;
    logic [4:0] lvl2;

    int n_tests = 0;
    int n_fail  = 0;

    rs232tx_buf #(.FREQUENCY(8), .BPS(1), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(16)) u_main (
        .clock(clk), .reset_n(rst_a[0]), .d(d0), .we(we_a[0]), .parity_mode(pm_a[0]),
        .serial_out(so_a[0]), .full(full_a[0]), .busy(busy_a[0]), .level(lvl0), .overflow(ovf_a[0]));

    rs232tx_buf #(.FREQUENCY(8), .BPS(1), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(4)) u_d4 (
        .clock(clk), .reset_n(rst_a[1]), .d(d1), .we(we_a[1]), .parity_mode(pm_a[1]),
        .serial_out(so_a[1]), .full(full_a[1]), .busy(busy_a[1]), .level(lvl1), .overflow(ovf_a[1]));

    rs232tx_buf #(.FREQUENCY(8), .BPS(1), .DATA_BITS(7), .STOP_BITS(2), .DEPTH(16)) u_s2 (
        .clock(clk), .reset_n(rst_a[2]), .d(d2), .we(we_a[2]), .parity_mode(pm_a[2]),
        .serial_out(so_a[2]), .full(full_a[2]), .busy(busy_a[2]), .level(lvl2), .overflow(ovf_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         u;
        logic [8:0] dv;
        logic [1:0] mode;
        logic [15:0] frame;
        int         nbits;
        string      nm;
    } vec_t;

    vec_t vecs [8];

    function automatic int lvl(input int u);
        case (u)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            default: return int'(lvl2);
        endcase
    endfunction

    task automatic set_d(input int u, input logic [8:0] v);
        case (u)
            0:       d0 = v[7:0];
            1:       d1 = v[7:0];
            default: d2 = v[6:0];
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Bit i of frame is the i-th bit on the line; each must hold for 8 cycles.
    task automatic run_frame(input int u, input logic [8:0] dv, input logic [1:0] mode,
                             input logic [15:0] frame, input int nbits, input string nm);
        int bad;
        set_d(u, dv);
        pm_a[u] = mode;
        we_a[u] = 1'b1;
        tick();
        we_a[u] = 1'b0;
        check({nm, "_line_at_write"}, int'(so_a[u]), 1);
        check({nm, "_level_at_write"}, lvl(u), 1);
        bad = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                if (i == 0 && c == 0) pm_a[u] = ~mode;
                if (so_a[u] !== frame[i]) bad++;
            end
        end
        check({nm, "_bad_bit_cycles"}, bad, 0);
        check({nm, "_busy_last_cycle"}, int'(busy_a[u]), 1);
        tick();
        check({nm, "_busy_after"}, int'(busy_a[u]), 0);
        check({nm, "_line_after"}, int'(so_a[u]), 1);
        pm_a[u] = 2'b00;
    endtask

    initial begin
        int bad, mx, ovbad, ovcnt;
        int badf [3];
        logic [15:0] fr [3];
        logic exp_ov;

        vecs[0] = '{0, 9'hA5, 2'b00, 16'h034A, 10, "a5_none"};
        vecs[3] = '{0, 9'h07, 2'b11, 16'h020E, 10, "p07_mode11"};
        vecs[6] = '{0, 9'hFF, 2'b00, 16'h03FE, 10, "ff_none"};
        vecs[7] = '{2, 9'h55, 2'b00, 16'h03AA, 10, "s2_d7_55"};
`ifdef RS232TX_PARITY_EN
        vecs[1] = '{0, 9'h07, 2'b01, 16'h060E, 11, "p07_even"};
        vecs[2] = '{0, 9'h07, 2'b10, 16'h040E, 11, "p07_odd"};
        vecs[4] = '{0, 9'h00, 2'b01, 16'h0400, 11, "p00_even"};
        vecs[5] = '{0, 9'h00, 2'b10, 16'h0600, 11, "p00_odd"};
`else
        vecs[1] = '{0, 9'h07, 2'b01, 16'h020E, 10, "p07_even"};
        vecs[2] = '{0, 9'h07, 2'b10, 16'h020E, 10, "p07_odd"};
        vecs[4] = '{0, 9'h00, 2'b01, 16'h0200, 10, "p00_even"};
        vecs[5] = '{0, 9'h00, 2'b10, 16'h0200, 10, "p00_odd"};
`endif

        for (int u = 0; u < 3; u++) begin
            rst_a[u] = 1'b0;
            we_a[u]  = 1'b0;
            pm_a[u]  = 2'b00;
        end
        d0 = '0; d1 = '0; d2 = '0;
        repeat (2) tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst%0d_line", u), int'(so_a[u]), 1);
            check($sformatf("rst%0d_busy", u), int'(busy_a[u]), 0);
            check($sformatf("rst%0d_full", u), int'(full_a[u]), 0);
            check($sformatf("rst%0d_ovf", u), int'(ovf_a[u]), 0);
            check($sformatf("rst%0d_level", u), lvl(u), 0);
        end
        for (int u = 0; u < 3; u++) rst_a[u] = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 8; k++)
            run_frame(vecs[k].u, vecs[k].dv, vecs[k].mode, vecs[k].frame, vecs[k].nbits, vecs[k].nm);

        // Three back-to-back writes: continuous frames, level peaks at 2.
        fr[0] = 16'h0202; fr[1] = 16'h0204; fr[2] = 16'h0206;
        for (int f = 0; f < 3; f++) badf[f] = 0;
        set_d(0, 9'h01);
        we_a[0] = 1'b1;
        tick();
        mx = lvl(0);
        for (int t = 1; t <= 240; t++) begin
            if (t == 1) set_d(0, 9'h02);
            else if (t == 2) set_d(0, 9'h03);
            else if (t == 3) we_a[0] = 1'b0;
            tick();
            if (lvl(0) > mx) mx = lvl(0);
            if (so_a[0] !== fr[(t - 1) / 80][((t - 1) / 8) % 10]) badf[(t - 1) / 80]++;
        end
        for (int f = 0; f < 3; f++) check($sformatf("b2b_frame%0d_bad_cycles", f), badf[f], 0);
        check("b2b_level_peak", mx, 2);
        check("b2b_busy_last", int'(busy_a[0]), 1);
        tick();
        check("b2b_busy_after", int'(busy_a[0]), 0);

        // DEPTH=4: six writes during a frame, then a write dropped on the pop cycle.
        set_d(1, 9'h0F);
        we_a[1] = 1'b1;
        tick();
        we_a[1] = 1'b0;
        mx = 0; ovbad = 0; ovcnt = 0;
        for (int t = 1; t <= 90; t++) begin
            we_a[1] = ((t >= 2 && t <= 7) || t == 81 || t == 82);
            set_d(1, 9'(t));
            @(negedge clk);
            exp_ov = (t == 6 || t == 7 || t == 81);
            if (ovf_a[1] !== exp_ov) ovbad++;
            if (ovf_a[1] === 1'b1) ovcnt++;
            tick();
            if (lvl(1) > mx) mx = lvl(1);
            if (t == 5) begin
                check("d4_level_filled", lvl(1), 4);
                check("d4_full_filled", int'(full_a[1]), 1);
            end
            if (t == 80) check("d4_level_held", lvl(1), 4);
            if (t == 81) begin
                check("d4_level_pop_drop", lvl(1), 3);
                check("d4_full_pop_drop", int'(full_a[1]), 0);
            end
            if (t == 82) begin
                check("d4_level_refill", lvl(1), 4);
                check("d4_full_refill", int'(full_a[1]), 1);
            end
        end
        we_a[1] = 1'b0;
        check("d4_ovf_pattern_errors", ovbad, 0);
        check("d4_ovf_pulses", ovcnt, 3);
        check("d4_level_max", mx, 4);

        // Asynchronous reset in the middle of a data bit with entries queued.
        set_d(0, 9'hA5);
        we_a[0] = 1'b1;
        tick();
        set_d(0, 9'h11);
        tick();
        set_d(0, 9'h22);
        tick();
        we_a[0] = 1'b0;
        repeat (18) tick();
        check("mid_line_before_rst", int'(so_a[0]), 0);
        check("mid_level_before_rst", lvl(0), 2);
        #2;
        rst_a[0] = 1'b0;
        #1;
        check("async_rst_line", int'(so_a[0]), 1);
        check("async_rst_level", lvl(0), 0);
        check("async_rst_busy", int'(busy_a[0]), 0);
        check("async_rst_full", int'(full_a[0]), 0);
        tick();
        tick();
        rst_a[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (so_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad++;
        end
        check("post_rst_idle_bad_cycles", bad, 0);
        run_frame(0, 9'hFF, 2'b00, 16'h03FE, 10, "post_rst_ff");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
